// File: rtl/rst_seq_pkg.sv
// rst_seq shared types: sequencer states and cause-bit offsets.
// Offsets are relative to N_SRC inside the cause vector.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RS_WAIT_LOCK,
    RS_HOLD,
    RS_RELEASE,
    RS_RUN
  } rst_state_t;

  localparam int CAUSE_LOCK_OFS = 0;
  localparam int CAUSE_WDT_OFS  = 1;

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq request/status bundle between board pins and the sequencer.
// master = pins/PLL/sysbus side, slave = the sequencer.
interface rst_seq_if #(
  parameter int N_SRC = 2,
  parameter int N_DOM = 4
);

  logic [N_SRC-1:0] src_req_n;
  logic             pll_locked;
  logic             wdt_kick;
  logic             cause_clr;
  logic [N_DOM-1:0] rst_out;
  logic             ready;
  logic [N_SRC+1:0] cause;

  modport master (
    output src_req_n, pll_locked,
    output wdt_kick, cause_clr,
    input  rst_out, ready, cause
  );

  modport slave (
    input  src_req_n, pll_locked,
    input  wdt_kick, cause_clr,
    output rst_out, ready, cause
  );

endinterface

// File: rtl/rst_seq_debounce.sv
// 2-FF synchroniser plus debounce counter for one active-low request.
// req is the debounced, active-high request level.
import rst_seq_pkg::*;

module rst_seq_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic req_n,
  output logic req
);

  localparam int W = $clog2(DEB_CYC + 1);
  localparam logic [W-1:0] LAST = W'(DEB_CYC - 1);

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      cnt <= '0;
      req <= 1'b0;
    end else begin
      s1 <= req_n;
      s2 <= s1;
      if (~s2 != req) begin
        if (cnt == LAST) begin
          req <= ~s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: debounced requests, PLL lock, hold, staggered release.
// Optional watchdog abort enabled with `define RST_SEQ_WDT_EN.
import rst_seq_pkg::*;

module rst_seq #(
  parameter int N_SRC     = 2,
  parameter int N_DOM     = 4,
  parameter int DEB_CYC   = 500000,
  parameter int HOLD_CYC  = 1024,
  parameter int STAGE_CYC = 16,
  parameter int WDT_CYC   = 50000000
) (
  input logic       clk,
  input logic       rst,
  rst_seq_if.slave  bus
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int SW = $clog2(STAGE_CYC + 1);
  localparam int WW = $clog2(WDT_CYC + 1);
  localparam int CW = N_SRC + 2;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_CYC - 1);
  localparam logic [N_DOM-1:0] TOP_BIT = N_DOM'(1) << (N_DOM - 1);

  rst_state_t       state;
  logic [HW-1:0]    hcnt;
  logic [SW-1:0]    scnt;
  logic [N_SRC-1:0] deb;
  logic             l1;
  logic             l2;
  logic             lock;
  logic             req_any;
  logic             active;
  logic             abort;
  logic             wdt_fire;
  logic [CW-1:0]    cause_set;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    rst_seq_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .req_n (bus.src_req_n[i]),
      .req   (deb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      l1 <= bus.pll_locked;
      l2 <= l1;
    end
  end

  assign lock    = l2;
  assign req_any = |deb;
  assign active  = (state == RS_RELEASE) ||
                   (state == RS_RUN);
  assign abort   = active &&
                   (!lock || req_any || wdt_fire);

`ifdef RST_SEQ_WDT_EN
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);
  logic [WW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state != RS_RUN || abort ||
                 bus.wdt_kick) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign wdt_fire = (state == RS_RUN) &&
                    !bus.wdt_kick &&
                    (wcnt == WDT_LAST);
`else
  logic [WW:0] unused_wdt;
  assign unused_wdt = {bus.wdt_kick, WW'(0)};
  assign wdt_fire   = 1'b0;
`endif

  always_comb begin
    cause_set = '0;
    if (abort) begin
      cause_set[N_SRC-1:0] = deb;
      cause_set[N_SRC+CAUSE_LOCK_OFS] = !lock;
      cause_set[N_SRC+CAUSE_WDT_OFS]  = wdt_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RS_WAIT_LOCK;
      hcnt        <= '0;
      scnt        <= '0;
      bus.rst_out <= '1;
      bus.ready   <= 1'b0;
      bus.cause   <= '0;
    end else begin
      bus.cause <= (bus.cause_clr ? '0 : bus.cause)
                 | cause_set;
      unique case (state)
        RS_WAIT_LOCK: begin
          if (lock) begin
            state <= RS_HOLD;
            hcnt  <= '0;
          end
        end
        RS_HOLD: begin
          if (!lock) begin
            state <= RS_WAIT_LOCK;
            hcnt  <= '0;
          end else if (req_any) begin
            hcnt <= '0;
          end else if (hcnt == HOLD_LAST) begin
            hcnt <= '0;
            scnt <= '0;
            if (N_DOM == 1) begin
              state       <= RS_RUN;
              bus.rst_out <= '0;
              bus.ready   <= 1'b1;
            end else begin
              state       <= RS_RELEASE;
              bus.rst_out <= ~N_DOM'(1);
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        RS_RELEASE, RS_RUN: begin
          if (abort) begin
            state       <= lock ? RS_HOLD
                                : RS_WAIT_LOCK;
            hcnt        <= '0;
            scnt        <= '0;
            bus.rst_out <= '1;
            bus.ready   <= 1'b0;
          end else if (state == RS_RELEASE) begin
            if (scnt == STG_LAST) begin
              scnt        <= '0;
              bus.rst_out <= bus.rst_out << 1;
              // dropping the last domain completes the sequence
              if (bus.rst_out == TOP_BIT) begin
                state     <= RS_RUN;
                bus.ready <= 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq against a cycle-level behavioural model.
// Watchdog expectations follow `define RST_SEQ_WDT_EN.
module tb_rst_seq;

  localparam int N_SRC = 2;
  localparam int N_DOM = 3;
  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STAGE = 2;
  localparam int WDT   = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  rst_seq_if #(.N_SRC(N_SRC), .N_DOM(N_DOM)) bus ();

  rst_seq #(
    .N_SRC     (N_SRC),
    .N_DOM     (N_DOM),
    .DEB_CYC   (DEB),
    .HOLD_CYC  (HOLD),
    .STAGE_CYC (STAGE),
    .WDT_CYC   (WDT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // behavioural model: phase 0 waiting lock, 1 holding, 2 released/running
  logic       armed;
  logic [1:0] m_d1, m_d2;
  logic       m_l1, m_l2;
  logic [1:0] m_deb;
  int         m_run [2];
  int         m_phase, m_q, m_e, m_w;
  logic [3:0] m_cause;

  function automatic int m_rel();
    int r;
    r = m_e / STAGE + 1;
    if (r > N_DOM) r = N_DOM;
    return r;
  endfunction

  function automatic logic [2:0] m_rst_out();
    logic [2:0] v;
    v = 3'((1 << m_rel()) - 1);
    return (m_phase == 2) ? ~v : 3'b111;
  endfunction

  function automatic logic m_ready();
    return (m_phase == 2) && (m_rel() == N_DOM);
  endfunction

  task automatic model_step(input logic r,
                            input logic [1:0] sn,
                            input logic pl,
                            input logic k,
                            input logic cc);
    logic lk, req, runm, fire;
    logic [3:0] set;
    if (r) begin
      armed = 1'b1;
      m_d1 = 2'b11; m_d2 = 2'b11;
      m_l1 = 1'b0; m_l2 = 1'b0;
      m_deb = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_phase = 0; m_q = 0; m_e = 0; m_w = 0;
      m_cause = 4'b0;
      return;
    end
    lk   = m_l2;
    req  = |m_deb;
    runm = m_ready();
    set  = 4'b0;
`ifdef RST_SEQ_WDT_EN
    fire = runm && !k && (m_w == WDT - 1);
`else
    fire = 1'b0;
`endif
    case (m_phase)
      0: if (lk) begin m_phase = 1; m_q = 0; end
      1: begin
        if (!lk) begin
          m_phase = 0; m_q = 0;
        end else if (req) begin
          m_q = 0;
        end else begin
          m_q++;
          if (m_q == HOLD) begin
            m_phase = 2; m_e = 0; m_q = 0;
          end
        end
      end
      default: begin
        if (!lk || req || fire) begin
          set = {fire, !lk, m_deb};
          m_phase = lk ? 1 : 0;
          m_q = 0; m_e = 0;
        end else if (m_e < STAGE * (N_DOM - 1)) begin
          m_e++;
        end
      end
    endcase
    m_w = (runm && !k && set == 4'b0) ? m_w + 1 : 0;
    m_cause = (cc ? 4'b0 : m_cause) | set;
    for (int i = 0; i < 2; i++) begin
      if (!m_d2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = !m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1; m_d1 = sn;
    m_l2 = m_l1; m_l1 = pl;
  endtask

  initial armed = 1'b0;

  always @(posedge clk) begin
    model_step(rst, bus.src_req_n, bus.pll_locked,
               bus.wdt_kick, bus.cause_clr);
    #1;
    if (armed) begin
      chk("rst_out", 32'(bus.rst_out), 32'(m_rst_out()));
      chk("ready", 32'(bus.ready), 32'(m_ready()));
      chk("cause", 32'(bus.cause), 32'(m_cause));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.ready) break;
    end
    chk("wait_ready", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_rel(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.rst_out == 3'b110) break;
    end
    chk("wait_rel", 32'(bus.rst_out), 32'b110);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    int rem [2];
    int prem;
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    bus.src_req_n  = 2'b11;
    bus.pll_locked = 1'b0;
    bus.wdt_kick   = 1'b0;
    bus.cause_clr  = 1'b0;
    tick(3);
    chk("reset_rst_out", 32'(bus.rst_out), 32'b111);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_cause", 32'(bus.cause), 32'd0);
    rst = 1'b0;

    // power-up: lock arrives after 20 cycles
    tick(20);
    chk("t1_wait", 32'(bus.rst_out), 32'b111);
    bus.pll_locked = 1'b1;
    tick(10);
    chk("t1_hold", 32'(bus.rst_out), 32'b111);
    tick(1);
    chk("t1_rel0", 32'(bus.rst_out), 32'b110);
    tick(1);
    chk("t1_rel0b", 32'(bus.rst_out), 32'b110);
    tick(1);
    chk("t1_rel1", 32'(bus.rst_out), 32'b100);
    tick(1);
    chk("t1_rel1b", 32'(bus.rst_out), 32'b100);
    tick(1);
    chk("t1_run", 32'(bus.rst_out), 32'b000);
    chk("t1_ready", 32'(bus.ready), 32'd1);
    chk("t1_cause", 32'(bus.cause), 32'd0);

    // short glitch ignored, long request after 7 cycles
    bus.src_req_n[0] = 1'b0;
    tick(3);
    bus.src_req_n[0] = 1'b1;
    tick(15);
    chk("t2_glitch", 32'(bus.ready), 32'd1);
    bus.src_req_n[0] = 1'b0;
    tick(6);
    chk("t2_lat6", 32'(bus.rst_out), 32'b000);
    tick(1);
    chk("t2_lat7", 32'(bus.rst_out), 32'b111);
    chk("t2_ready", 32'(bus.ready), 32'd0);
    chk("t2_cause", 32'(bus.cause), 32'b0001);
    tick(5);
    bus.src_req_n[0] = 1'b1;
    wait_ready(200);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    chk("t2_clr", 32'(bus.cause), 32'd0);

    // long request keeps HOLD; hold count starts after release
    bus.src_req_n[1] = 1'b0;
    tick(7);
    chk("t3_abort", 32'(bus.rst_out), 32'b111);
    chk("t3_cause", 32'(bus.cause), 32'b0010);
    tick(93);
    chk("t3_held", 32'(bus.rst_out), 32'b111);
    bus.src_req_n[1] = 1'b1;
    tick(13);
    chk("t3_hold13", 32'(bus.rst_out), 32'b111);
    tick(1);
    chk("t3_rel", 32'(bus.rst_out), 32'b110);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    chk("t3_clr", 32'(bus.cause), 32'd0);
    wait_ready(200);

    // lock loss during release
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_rel(200);
    bus.pll_locked = 1'b0;
    tick(3);
    chk("t4_rst_out", 32'(bus.rst_out), 32'b111);
    chk("t4_ready", 32'(bus.ready), 32'd0);
    chk("t4_cause", 32'(bus.cause), 32'b0100);
    bus.pll_locked = 1'b1;
    wait_ready(200);
    chk("t4_run", 32'(bus.rst_out), 32'b000);

    // rst mid-release clears everything
    bus.src_req_n[0] = 1'b0;
    tick(8);
    bus.src_req_n[0] = 1'b1;
    wait_rel(200);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_out", 32'(bus.rst_out), 32'b111);
    chk("t5_ready", 32'(bus.ready), 32'd0);
    chk("t5_cause", 32'(bus.cause), 32'd0);
    rst = 1'b0;
    wait_ready(200);
    bus.cause_clr    = 1'b1;
    bus.src_req_n[0] = 1'b0;
    tick(7);
    chk("t5_setwins", 32'(bus.cause), 32'b0001);
    bus.cause_clr    = 1'b0;
    bus.src_req_n[0] = 1'b1;
    wait_ready(200);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;

`ifdef RST_SEQ_WDT_EN
    for (int i = 0; i < 10; i++) begin
      tick(19);
      bus.wdt_kick = 1'b1;
      tick(1);
      bus.wdt_kick = 1'b0;
    end
    chk("t6_kicked", 32'(bus.ready), 32'd1);
    tick(31);
    chk("t6_wdt31", 32'(bus.ready), 32'd1);
    tick(1);
    chk("t6_wdt32", 32'(bus.ready), 32'd0);
    chk("t6_cause", 32'(bus.cause), 32'b1000);
`else
    tick(1000);
    chk("t6_nowdt", 32'(bus.ready), 32'd1);
    chk("t6_cause3", 32'(bus.cause[3]), 32'd0);
`endif

    // random traffic against the model
    rem[0] = 0; rem[1] = 0; prem = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          bus.src_req_n[i] = ($urandom_range(0, 5) != 0);
          rem[i] = $urandom_range(1, 30);
        end else begin
          rem[i]--;
        end
      end
      if (prem > 0) begin
        prem--;
        if (prem == 0) bus.pll_locked = 1'b1;
      end else if ($urandom_range(0, 400) == 0) begin
        bus.pll_locked = 1'b0;
        prem = $urandom_range(1, 10);
      end
      bus.wdt_kick  = ($urandom_range(0, 39) == 0);
      bus.cause_clr = ($urandom_range(0, 49) == 0);
      rst           = ($urandom_range(0, 1999) == 0);
    end
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
